// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 frame definitions: FSM state encoding, frame constants and parity.
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_RTS, ST_SHIFT, ST_ACK, ST_WAITREL
  } state_e;

  localparam int PS2_NBITS    = 11;
  localparam int PS2_STOP_IDX = 10;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// 2-FF synchroniser, FILT_LEN-sample glitch filter and registered falling-edge
// pulse for one PS/2 line.
module ps2_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);
  logic [1:0]          sync_q;
  logic [FILT_LEN-1:0] hist_q;
  logic                filt_q, filt_d, fall_q;

  // Level changes only once FILT_LEN consecutive samples agree.
  always_comb begin
    filt_d = filt_q;
    if (&hist_q)       filt_d = 1'b1;
    else if (~|hist_q) filt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
      filt_q <= filt_d;
      fall_q <= filt_q & ~filt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock falls, then collect the device acknowledge.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int FILT_LEN       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kclk_i,
  input  logic       kdat_i,
  output logic       kclk_oe,
  output logic       kdat_oe,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    N_STOP   = 4'(PS2_STOP_IDX - 1);

  state_e               state_q;
  logic [IW-1:0]        inh_q;
  logic [TW-1:0]        to_q;
  logic [3:0]           n_q;
  logic [PS2_NBITS-3:0] sh_q;
  logic [1:0]           kdat_sync_q;
  logic                 ack_ok_q, kclk_oe_q, kdat_oe_q, busy_q, done_q, err_q;
  logic                 kclk_filt, kclk_fall, kdat_s;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_kclk_filt (
    .clk    (clk),
    .rst    (reset),
    .line_i (kclk_i),
    .filt_o (kclk_filt),
    .fall_o (kclk_fall)
  );

  assign kdat_s = kdat_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      inh_q       <= '0;
      to_q        <= '0;
      n_q         <= '0;
      sh_q        <= '0;
      kdat_sync_q <= '1;
      ack_ok_q    <= 1'b0;
      kclk_oe_q   <= 1'b0;
      kdat_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      kdat_sync_q <= {kdat_sync_q[0], kdat_i};
      done_q      <= 1'b0;
      if (state_q inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAITREL}) to_q <= to_q + 1'b1;
      case (state_q)
        ST_IDLE: if (wr) begin
          sh_q      <= {odd_par(data), data};
          busy_q    <= 1'b1;
          err_q     <= 1'b0;
          kclk_oe_q <= 1'b1;
          kdat_oe_q <= (INHIBIT_CYCLES == 1);
          inh_q     <= '0;
          state_q   <= ST_INHIBIT;
        end
        ST_INHIBIT: begin
          inh_q <= inh_q + 1'b1;
          // Start bit goes down in the final inhibit cycle, the only overlap.
          if (inh_q + 1'b1 == INH_LAST) kdat_oe_q <= 1'b1;
          if (inh_q == INH_LAST) begin
            kclk_oe_q <= 1'b0;
            to_q      <= '0;
            n_q       <= '0;
            state_q   <= ST_RTS;
          end
        end
        default: begin
          if (to_q == TO_LAST) begin
            kclk_oe_q <= 1'b0;
            kdat_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            case (state_q)
              ST_RTS, ST_SHIFT: if (kclk_fall) begin
                n_q <= (n_q == 4'hF) ? n_q : n_q + 4'd1;
                if (n_q == N_STOP) begin
                  kdat_oe_q <= 1'b0;
                  state_q   <= ST_ACK;
                end else begin
                  kdat_oe_q <= ~sh_q[0];
                  sh_q      <= {1'b1, sh_q[PS2_NBITS-3:1]};
                  state_q   <= ST_SHIFT;
                end
              end
              ST_ACK: if (kclk_fall) begin
                ack_ok_q <= ~kdat_s;
                state_q  <= ST_WAITREL;
              end
              ST_WAITREL: if (kclk_filt && kdat_s) begin
                done_q  <= 1'b1;
                err_q   <= ~ack_ok_q;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign kclk_oe = kclk_oe_q;
  assign kdat_oe = kdat_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the
// host; a monitor checks every done pulse against a queue of expected results.
module tb_ps2_host_tx;
  localparam int INH = 20, TMO = 2000, FL = 4, HALF = 20;

  logic       clk = 1'b0, reset;
  logic       kclk_i, kdat_i, kclk_oe, kdat_oe, wr, busy, done, err;
  logic [7:0] data;
  logic       dev_kclk, dev_kdat;

  assign kclk_i = dev_kclk & ~kclk_oe;
  assign kdat_i = dev_kdat & ~kdat_oe;
  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILT_LEN(FL)) dut (
    .clk(clk), .reset(reset), .kclk_i(kclk_i), .kdat_i(kdat_i),
    .kclk_oe(kclk_oe), .kdat_oe(kdat_oe), .data(data), .wr(wr),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed { logic [9:0] frame; logic chk_frame; logic err; } exp_t;
  typedef struct { logic [7:0] d; logic [9:0] frame; bit ack; bit glitch; bit err; } vec_t;

  exp_t       exp_q[$];
  int         checks = 0, errors = 0, done_cnt = 0;
  logic [9:0] dev_bits;
  int         dev_bitcnt = 0;
  bit         dev_abort = 0, dev_busy = 0;
  int         klo_run = 0, inh_len = 0, kdat_at = 0;
  logic       kdat_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: inhibit timing capture and scoreboard on every done pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (kclk_oe) begin
      klo_run++;
      if (kdat_oe && !kdat_prev) kdat_at = klo_run;
    end else begin
      if (klo_run != 0) inh_len = klo_run;
      klo_run = 0;
    end
    kdat_prev = kdat_oe;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        e = exp_q.pop_front();
        chk("done_err", err, e.err);
        chk("done_busy", busy, 0);
        chk("done_kclk_oe", kclk_oe, 0);
        chk("done_kdat_oe", kdat_oe, 0);
        if (e.chk_frame) chk("frame_bits", dev_bits, e.frame);
      end
    end
  end

  task automatic dwait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) @(negedge clk);
  endtask

  // Device: waits for request-to-send, issues 10 clocks sampling KDAT at the
  // end of each low phase, then an 11th clock carrying the acknowledge.
  task automatic dev_xfer(input bit do_ack, input bit glitch);
    int t = 0;
    dev_busy = 1; dev_bitcnt = 0;
    while (!(kclk_oe === 1'b0 && kdat_oe === 1'b1 && busy === 1'b1) && t < 500 && !dev_abort) begin
      @(negedge clk); t++;
    end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL dev_rts_wait: got no request-to-send expected one within 500 cycles");
    end else begin
      dwait(10);
      for (int i = 0; i < 10 && !dev_abort; i++) begin
        dev_kclk = 1'b0; dev_bitcnt = i + 1;
        dwait(HALF);
        dev_bits[i] = kdat_i;
        dev_kclk = 1'b1;
        if (glitch) begin
          dwait(HALF/2); dev_kclk = 1'b0; dwait(1); dev_kclk = 1'b1; dwait(HALF/2);
        end else dwait(HALF);
      end
      if (!dev_abort) begin
        dev_kdat = do_ack ? 1'b0 : 1'b1;
        dwait(5); dev_kclk = 1'b0; dwait(HALF); dev_kclk = 1'b1; dwait(5);
      end
    end
    dev_kclk = 1'b1; dev_kdat = 1'b1; dev_busy = 0;
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk); data = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int n0, input int bound);
    int t = 0;
    while (done_cnt == n0 && t < bound) begin @(negedge clk); #1; t++; end
    if (done_cnt == n0) begin
      checks++; errors++;
      $display("FAIL %s: got no done expected done within %0d cycles", nm, bound);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   n0, cnt, t;
    vecs[0] = '{d: 8'hED, frame: 10'h3ED, ack: 1, glitch: 0, err: 0};
    vecs[1] = '{d: 8'hF4, frame: 10'h2F4, ack: 1, glitch: 0, err: 0};
    vecs[2] = '{d: 8'hA5, frame: 10'h3A5, ack: 0, glitch: 0, err: 1};
    vecs[3] = '{d: 8'h01, frame: 10'h201, ack: 1, glitch: 1, err: 0};

    reset = 1'b1; wr = 1'b0; data = '0; dev_kclk = 1'b1; dev_kdat = 1'b1; dev_bits = '0;
    repeat (3) @(negedge clk);
    chk("rst_kclk_oe", kclk_oe, 0);
    chk("rst_kdat_oe", kdat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      n0 = done_cnt;
      exp_q.push_back('{frame: vecs[i].frame, chk_frame: 1'b1, err: vecs[i].err});
      send(vecs[i].d);
      chk("busy_after_wr", busy, 1);
      dev_xfer(vecs[i].ack, vecs[i].glitch);
      wait_done("xfer_done", n0, 200);
      @(negedge clk);
      chk("busy_idle", busy, 0);
      if (vecs[i].d == 8'hF4) begin
        chk("inhibit_len", inh_len, INH);
        chk("start_bit_cycle", kdat_at, INH);
      end
    end

    // Device stays silent: abort exactly TMO cycles after KCLK release.
    n0 = done_cnt;
    exp_q.push_back('{frame: 10'h0, chk_frame: 1'b0, err: 1'b1});
    send(8'h3C);
    t = 0;
    while (!(kclk_oe === 1'b0 && kdat_oe === 1'b1) && t < 100) begin @(negedge clk); t++; end
    chk("timeout_rts_seen", (t < 100), 1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 3*TMO) begin @(negedge clk); cnt++; end
    chk("timeout_cycles", cnt, TMO);
    chk("timeout_kdat_oe", kdat_oe, 0);
    wait_done("timeout_done", n0, 10);
    @(negedge clk);
    chk("timeout_busy", busy, 0);

    // Second wr mid-frame is ignored; reset at bit 5 drops everything at once.
    n0 = done_cnt;
    send(8'h00);
    chk("busy_after_wr2", busy, 1);
    fork dev_xfer(1'b1, 1'b0); join_none
    t = 0;
    while (dev_bitcnt < 2 && t < 2000) begin @(negedge clk); t++; end
    send(8'hAA);
    t = 0;
    while (dev_bitcnt < 5 && t < 2000) begin @(negedge clk); t++; end
    chk("reached_bit5", dev_bitcnt, 5);
    repeat (HALF/2) @(negedge clk);
    chk("pre_reset_kdat_oe", kdat_oe, 1);
    reset = 1'b1;
    #1;
    chk("async_kclk_oe", kclk_oe, 0);
    chk("async_kdat_oe", kdat_oe, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    dev_abort = 1;
    t = 0;
    while (dev_busy && t < 100) begin @(negedge clk); t++; end
    dev_abort = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", done_cnt, n0);

    exp_q.push_back('{frame: 10'h3FF, chk_frame: 1'b1, err: 1'b0});
    send(8'hFF);
    dev_xfer(1'b1, 1'b0);
    wait_done("post_reset_done", n0, 200);
    repeat (2) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. The keyboard port is otherwise receive-only; this block lets the system send command bytes to the keyboard (0xED set LEDs, 0xF4 enable, 0xFF reset).
- Drives the open-drain KCLK/KDAT lines through pull-low enables and runs the full request-to-send, shift and acknowledge sequence.
- Sits inside SYSTEM beside the PS/2 receiver. `busy` tells the receiver to ignore line activity while a send is in progress.

Parameters:
- INHIBIT_CYCLES, 3000: clk cycles that KCLK is held low before request-to-send (120 µs at 25 MHz).
- TIMEOUT_CYCLES, 400000: maximum clk cycles from KCLK release to acknowledge before aborting (16 ms at 25 MHz).
- FILT_LEN, 4: consecutive equal synchronised samples required before the filtered KCLK level changes.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- kclk_i  input  1  raw KCLK pin level
- kdat_i  input  1  raw KDAT pin level
- kclk_oe  output  1  1 = pull KCLK low; 0 = release
- kdat_oe  output  1  1 = pull KDAT low; 0 = release
- data  input  8  byte to send; captured when wr is accepted
- wr  input  1  one-cycle start strobe
- busy  output  1  high from wr acceptance until done
- done  output  1  one-cycle pulse at the end of every transfer
- err  output  1  valid only while done=1; 1 = no acknowledge, or timeout

Behaviour:
- Reset (asynchronous, active-high): state IDLE, kclk_oe=0, kdat_oe=0, busy=0, done=0, err=0, counters cleared, filtered KCLK=1.
- Input conditioning:
  - kclk_i passes through a 2-FF synchroniser and a FILT_LEN glitch filter.
  - kdat_i passes through a 2-FF synchroniser only.
  - fall = filtered KCLK 1→0, registered; one-cycle pulse.
- IDLE:
  - wr=1 → capture data, compute odd parity (par = ~^data), busy=1, go to INHIBIT.
  - wr while busy=1 is ignored. The byte is not captured and no done is produced for it.
- INHIBIT:
  - kclk_oe=1 for INHIBIT_CYCLES cycles.
  - In the last cycle: kdat_oe=1 (start bit 0), then go to RTS.
- RTS:
  - kclk_oe=0, kdat_oe=1.
  - Timeout counter cleared and starts.
  - Bit counter n=0.
- Shift (RTS and SHIFT): on each fall, n increments and kdat_oe is updated in the next cycle:
  - n=1..8: kdat_oe = ~data[n-1] (LSB first)
  - n=9: kdat_oe = ~par
  - n=10: kdat_oe=0 (stop bit, line released), go to ACK
- ACK:
  - On fall, sample synchronised KDAT: ack_ok = (KDAT==0).
  - Go to WAITREL.
- WAITREL:
  - Wait until filtered KCLK=1 and synchronised KDAT=1.
  - Then done=1 for one cycle, err=~ack_ok, busy=0, go to IDLE.
- Timeout:
  - Applies in RTS, SHIFT, ACK and WAITREL.
  - Counter reaching TIMEOUT_CYCLES → kclk_oe=0, kdat_oe=0, done=1, err=1, busy=0, go to IDLE in the same cycle.
  - Timeout takes priority over a simultaneous fall.
- kclk_oe and kdat_oe are never both asserted outside the INHIBIT→RTS handover cycle.
- kclk_oe is never asserted outside INHIBIT.
- Reset mid-transfer releases both lines immediately (asynchronous); no done pulse.
- Latency: kdat_oe changes at most 2 + FILT_LEN + 2 clk cycles after the raw KCLK falling edge. This is well inside the ≥30 µs device low phase.
- Counter widths: ceil(log2(param+1)) bits. n is 4 bits and saturates; it does not wrap.

Decomposition:
- Shared include ps2_defs.v holds:
  - state encodings: IDLE, INHIBIT, RTS, SHIFT, ACK, WAITREL
  - frame constants: PS2_NBITS=11, PS2_STOP_IDX=10
  - the parity function
  - The PS/2 receiver uses the same include.
- One sub-module: ps2_line_filter (2-FF synchroniser plus FILT_LEN filter and falling-edge pulse). The receiver also reuses it.

Test Plan:
- data=0xED, device model clocks at 12.5 kHz and acks → KDAT bits after the start bit are 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1 with err=0; busy low afterwards.
- data=0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0; KCLK held low ≥ INHIBIT_CYCLES before KDAT asserted; done with err=0.
- Device omits the ack (KDAT high on the 11th clock) → done=1, err=1; both oe=0.
- Device never clocks after RTS → exactly TIMEOUT_CYCLES after KCLK release: done=1, err=1, kdat_oe=0, state IDLE.
- 1-cycle glitches on KCLK (shorter than FILT_LEN) during SHIFT → no extra bit shifted; byte 0x01 arrives intact (data bits 1,0,0,0,0,0,0,0, parity 0).
- wr pulsed again mid-transfer, then reset asserted at bit 5 → second wr ignored; on reset kclk_oe=kdat_oe=busy=done=0 immediately; a new wr with data=0xFF succeeds (parity 1).
